// File: rtl/rv32imf_pkg.sv
// ============================================================================
// rv32imf_pkg : shared types and constants for the RV32M serial multiplier
// Rev 1.0
// ============================================================================
`default_nettype none

package rv32imf_pkg;

  localparam int C_WIDTH_DFLT = 32;

  typedef enum logic [1:0] {
    OP_MUL    = 2'd0,
    OP_MULH   = 2'd1,
    OP_MULHSU = 2'd2,
    OP_MULHU  = 2'd3
  } mul_op_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MULTIPLY = 2'd1,
    ST_FINISH   = 2'd2
  } mul_state_e;

endpackage

`default_nettype wire

// File: rtl/rv32imf_mul_opnd_cond.sv
// ============================================================================
// rv32imf_mul_opnd_cond : sign detect and magnitude of one multiplier operand
// Rev 1.0
// ============================================================================
`default_nettype none

module rv32imf_mul_opnd_cond #(
  parameter int C_WIDTH = 32
) (
  input  logic [C_WIDTH-1:0] Op_DI,
  input  logic               SgnEn_SI,
  output logic               Sgn_SO,
  output logic [C_WIDTH-1:0] Mag_DO
);

  assign Sgn_SO = SgnEn_SI & Op_DI[C_WIDTH-1];
  // Most-negative value maps onto itself, which is its correct unsigned magnitude.
  assign Mag_DO = Sgn_SO ? (~Op_DI + C_WIDTH'(1)) : Op_DI;

endmodule

`default_nettype wire

// File: rtl/rv32imf_alu_mul_ser.sv
// ============================================================================
// rv32imf_alu_mul_ser : iterative radix-2 shift-add MUL/MULH/MULHSU/MULHU
// Optional early termination: RV32IMF_MUL_EARLY_OUT_EN.   Rev 1.0
// ============================================================================
`default_nettype none

module rv32imf_alu_mul_ser
  import rv32imf_pkg::*;
#(
  parameter int C_WIDTH     = C_WIDTH_DFLT,
  parameter int C_LOG_WIDTH = 6
) (
  input  logic               Clk_CI,
  input  logic               Rst_RI,
  input  logic [C_WIDTH-1:0] OpA_DI,
  input  logic [C_WIDTH-1:0] OpB_DI,
  input  logic [1:0]         OpCode_SI,
  input  logic               InVld_SI,
  output logic               InRdy_SO,
  output logic               OutVld_SO,
  input  logic               OutRdy_SI,
  output logic [C_WIDTH-1:0] Res_DO
);

  mul_op_e                  op;
  logic                     a_sgn, b_sgn;
  logic [C_WIDTH-1:0]       a_mag, b_mag;

  mul_state_e               state_q, state_d;
  logic [2*C_WIDTH-1:0]     areg_q, areg_d;
  logic [C_WIDTH-1:0]       breg_q, breg_d;
  logic [2*C_WIDTH-1:0]     acc_q, acc_d;
  logic [C_LOG_WIDTH-1:0]   cnt_q, cnt_d;
  logic                     res_inv_q, res_inv_d;
  logic                     hi_sel_q, hi_sel_d;
  logic                     in_rdy_q, in_rdy_d;
  logic                     out_vld_q, out_vld_d;
  logic                     done;
  logic [2*C_WIDTH-1:0]     prod;

  assign op = mul_op_e'(OpCode_SI);

  rv32imf_mul_opnd_cond #(.C_WIDTH(C_WIDTH)) u_cond_a (
    .Op_DI    (OpA_DI),
    .SgnEn_SI ((op == OP_MULH) || (op == OP_MULHSU)),
    .Sgn_SO   (a_sgn),
    .Mag_DO   (a_mag)
  );

  rv32imf_mul_opnd_cond #(.C_WIDTH(C_WIDTH)) u_cond_b (
    .Op_DI    (OpB_DI),
    .SgnEn_SI (op == OP_MULH),
    .Sgn_SO   (b_sgn),
    .Mag_DO   (b_mag)
  );

  always_comb begin
    state_d   = state_q;
    areg_d    = areg_q;
    breg_d    = breg_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    res_inv_d = res_inv_q;
    hi_sel_d  = hi_sel_q;
    in_rdy_d  = in_rdy_q;
    out_vld_d = out_vld_q;
    done      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (InVld_SI) begin
          areg_d    = {{C_WIDTH{1'b0}}, a_mag};
          breg_d    = b_mag;
          acc_d     = '0;
          res_inv_d = a_sgn ^ b_sgn;
          hi_sel_d  = (op != OP_MUL);
          cnt_d     = C_LOG_WIDTH'(C_WIDTH - 1);
          state_d   = ST_MULTIPLY;
          in_rdy_d  = 1'b0;
        end
      end
      ST_MULTIPLY: begin
        if (breg_q[0]) begin
          acc_d = acc_q + areg_q;
        end
        areg_d = areg_q << 1;
        breg_d = breg_q >> 1;
        cnt_d  = cnt_q - C_LOG_WIDTH'(1);
        done   = (cnt_q == '0);
`ifdef RV32IMF_MUL_EARLY_OUT_EN
        // No multiplier bits left means every further step adds zero.
        done   = done || (breg_d == '0);
`endif
        if (done) begin
          state_d   = ST_FINISH;
          out_vld_d = 1'b1;
        end
      end
      ST_FINISH: begin
        if (OutRdy_SI) begin
          state_d   = ST_IDLE;
          out_vld_d = 1'b0;
          in_rdy_d  = 1'b1;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        in_rdy_d  = 1'b1;
        out_vld_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk_CI or posedge Rst_RI) begin
    if (Rst_RI) begin
      state_q   <= ST_IDLE;
      areg_q    <= '0;
      breg_q    <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      res_inv_q <= 1'b0;
      hi_sel_q  <= 1'b0;
      in_rdy_q  <= 1'b1;
      out_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      areg_q    <= areg_d;
      breg_q    <= breg_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      res_inv_q <= res_inv_d;
      hi_sel_q  <= hi_sel_d;
      in_rdy_q  <= in_rdy_d;
      out_vld_q <= out_vld_d;
    end
  end

  // Sign fix-up spans the full double-width product so the high half is right.
  assign prod      = res_inv_q ? (~acc_q + (2*C_WIDTH)'(1)) : acc_q;
  assign Res_DO    = hi_sel_q ? prod[2*C_WIDTH-1:C_WIDTH] : prod[C_WIDTH-1:0];
  assign InRdy_SO  = in_rdy_q;
  assign OutVld_SO = out_vld_q;

endmodule

`default_nettype wire
